// File: rtl/sim_run_controller.sv
// Run controller for processor bring-up: sequences the core reset, budgets RUN
// cycles, detects halt from the observed state code and keeps a circular state trace.
module sim_run_controller #(
    parameter int                      CNT_WIDTH   = 16,
    parameter int                      MAX_CYCLES  = 64,
    parameter int                      RST_CYCLES  = 2,
    parameter int                      STATE_WIDTH = 5,
    parameter logic [STATE_WIDTH-1:0]  HALT_STATE  = 5'd31,
    parameter int                      HALT_HOLD   = 2,
    parameter int                      TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [STATE_WIDTH-1:0]         stateOut,
    output logic                           core_reset,
    output logic                           running,
    output logic                           done,
    output logic                           timeout,
    output logic [CNT_WIDTH-1:0]           cycle_count,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [STATE_WIDTH-1:0]         trace_rd_data
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int TC_W  = PTR_W + 1;
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int HR_W  = $clog2(HALT_HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    state_t                  state_q, state_d;
    logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
    logic [HR_W-1:0]         halt_run_q, halt_run_d;
    logic [CNT_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [TC_W-1:0]         trace_cnt_q, trace_cnt_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic                    core_reset_q, core_reset_d;
    logic                    running_q, running_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [STATE_WIDTH-1:0]  trace_mem_q [TRACE_DEPTH];
    logic [STATE_WIDTH-1:0]  trace_mem_d [TRACE_DEPTH];

    logic                    is_halt_code;
    logic                    halt_hit;
    logic                    budget_hit;
    logic                    rst_expired;
    logic [PTR_W-1:0]        rd_addr;

    assign is_halt_code = (stateOut == HALT_STATE);
    assign halt_hit     = is_halt_code && (halt_run_q == HR_W'(HALT_HOLD - 1));
    assign budget_hit   = (cycle_cnt_q == CNT_WIDTH'(MAX_CYCLES - 1));
    assign rst_expired  = (rst_cnt_q == '0);

    // State register plus the counters and flags that travel with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            halt_run_q   <= '0;
            cycle_cnt_q  <= '0;
            trace_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            halt_run_q   <= halt_run_d;
            cycle_cnt_q  <= cycle_cnt_d;
            trace_cnt_q  <= trace_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        trace_mem_q <= trace_mem_d;
    end

    // Next-state logic; halt is tested before budget so a tie ends in HALTED
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) state_d = S_HOLD_RST;
            end
            S_HOLD_RST: begin
                if (rst_expired) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt_hit)        state_d = S_HALTED;
                else if (budget_hit) state_d = S_TIMEOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rst_cnt_d   = rst_cnt_q;
        halt_run_d  = halt_run_q;
        cycle_cnt_d = cycle_cnt_q;
        trace_cnt_d = trace_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        trace_mem_d = trace_mem_q;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start) rst_cnt_d = RC_W'(RST_CYCLES - 1);
            end
            S_HOLD_RST: begin
                if (rst_expired) begin
                    cycle_cnt_d = '0;
                    halt_run_d  = '0;
                    trace_cnt_d = '0;
                    wr_ptr_d    = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            S_RUN: begin
                // The exit edge is counted and traced like any other RUN edge
                cycle_cnt_d           = cycle_cnt_q + CNT_WIDTH'(1);
                trace_mem_d[wr_ptr_q] = stateOut;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                if (trace_cnt_q != TC_W'(TRACE_DEPTH))
                    trace_cnt_d = trace_cnt_q + TC_W'(1);
                halt_run_d = is_halt_code ? (halt_run_q + HR_W'(1)) : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        core_reset_d = (state_d != S_RUN);
        running_d    = (state_d == S_RUN);
        done_d       = (state_d == S_HALTED);
        timeout_d    = (state_d == S_TIMEOUT);
    end

    assign rd_addr       = wr_ptr_q - PTR_W'(1) - trace_rd_idx;
    assign trace_rd_data = ({1'b0, trace_rd_idx} < trace_cnt_q) ? trace_mem_q[rd_addr] : '0;

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_cnt_q;
    assign trace_count = trace_cnt_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Randomized bench for sim_run_controller against a run-level reference model
// (halt = HALT_HOLD consecutive halt codes, else timeout at the budget).
module tb_sim_run_controller;

    localparam int MAXC  = 64;
    localparam int HH    = 2;
    localparam int DEPTH = 8;
    localparam int MAXC4 = 4;
    localparam int HH4   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start4;
    logic [4:0]  state_in, state4;
    logic        core_reset, running, done, timeout;
    logic        core_reset4, running4, done4, timeout4;
    logic [15:0] cycle_count, cycle_count4;
    logic [3:0]  trace_count, trace_count4;
    logic [2:0]  rd_idx, rd_idx4;
    logic [4:0]  rd_data, rd_data4;

    logic [4:0]  pat [256];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sim_run_controller u_dut (
        .clk(clk), .reset(reset), .start(start), .stateOut(state_in),
        .core_reset(core_reset), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .trace_count(trace_count),
        .trace_rd_idx(rd_idx), .trace_rd_data(rd_data)
    );

    sim_run_controller #(.MAX_CYCLES(MAXC4), .HALT_HOLD(HH4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .stateOut(state4),
        .core_reset(core_reset4), .running(running4), .done(done4), .timeout(timeout4),
        .cycle_count(cycle_count4), .trace_count(trace_count4),
        .trace_rd_idx(rd_idx4), .trace_rd_data(rd_data4)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: scan RUN cycles 1.. and stop at the first run of hh halt codes or at the budget
    function automatic void model_run(input int maxc, input int hh, output int len, output bit halted);
        int hr;
        hr     = 0;
        len    = maxc;
        halted = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            if (pat[k] == 5'd31) hr++;
            else hr = 0;
            if (hr >= hh) begin
                halted = 1'b1;
                len    = k;
                return;
            end
        end
    endfunction

    task automatic fill_random(input int pct31);
        for (int k = 0; k < 256; k++)
            pat[k] = ($urandom_range(99) < pct31) ? 5'd31 : 5'($urandom_range(30));
    endtask

    task automatic do_run(input string tag);
        int len, run_cyc, ntr;
        bit halted, fin;
        logic [4:0] exp;
        model_run(MAXC, HH, len, halted);
        @(posedge clk); #1 start = 1'b1; state_in = 5'd0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk_eq({tag, "/cr_hold0"}, core_reset, 1);
        chk_eq({tag, "/run_hold0"}, running, 0);
        chk_eq({tag, "/done_clr"}, done, 0);
        chk_eq({tag, "/tmo_clr"}, timeout, 0);
        @(posedge clk); @(negedge clk);
        chk_eq({tag, "/cr_hold1"}, core_reset, 1);
        chk_eq({tag, "/run_hold1"}, running, 0);
        run_cyc = 0;
        fin     = 1'b0;
        for (int c = 0; c < MAXC + 8 && !fin; c++) begin
            @(posedge clk); #1 state_in = pat[c + 1];
            @(negedge clk);
            if (c == 0) chk_eq({tag, "/cr_run"}, core_reset, 0);
            if (running) run_cyc++;
            else fin = 1'b1;
        end
        chk_eq({tag, "/exit_seen"}, fin, 1);
        chk_eq({tag, "/run_len"}, run_cyc, len);
        chk_eq({tag, "/done"}, done, halted);
        chk_eq({tag, "/timeout"}, timeout, !halted);
        chk_eq({tag, "/cycle_count"}, cycle_count, len);
        chk_eq({tag, "/cr_after"}, core_reset, 1);
        ntr = (len < DEPTH) ? len : DEPTH;
        chk_eq({tag, "/trace_count"}, trace_count, ntr);
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 3'(i);
            #1;
            exp = (i < ntr) ? pat[len - i] : 5'd0;
            chk_eq($sformatf("%s/trace%0d", tag, i), rd_data, exp);
        end
        rd_idx = 3'd0;
    endtask

    task automatic do_run4(input string tag);
        int len, run_cyc;
        bit halted, fin;
        model_run(MAXC4, HH4, len, halted);
        @(posedge clk); #1 start4 = 1'b1; state4 = 5'd0;
        @(posedge clk); #1 start4 = 1'b0;
        @(posedge clk);
        run_cyc = 0;
        fin     = 1'b0;
        for (int c = 0; c < MAXC4 + 8 && !fin; c++) begin
            @(posedge clk); #1 state4 = pat[c + 1];
            @(negedge clk);
            if (running4) run_cyc++;
            else fin = 1'b1;
        end
        chk_eq({tag, "/exit_seen"}, fin, 1);
        chk_eq({tag, "/run_len"}, run_cyc, len);
        chk_eq({tag, "/done"}, done4, halted);
        chk_eq({tag, "/timeout"}, timeout4, !halted);
        chk_eq({tag, "/cycle_count"}, cycle_count4, len);
        chk_eq({tag, "/cr_after"}, core_reset4, 1);
        chk_eq({tag, "/trace_count"}, trace_count4, len);
        rd_idx4 = 3'd0;
        #1 chk_eq({tag, "/trace0"}, rd_data4, pat[len]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start4 = 1'b0;
        state_in = 5'd0; state4 = 5'd0; rd_idx = 3'd0; rd_idx4 = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst/core_reset", core_reset, 1);
        chk_eq("rst/running", running, 0);
        chk_eq("rst/done", done, 0);
        chk_eq("rst/timeout", timeout, 0);
        chk_eq("rst/cycle_count", cycle_count, 0);
        chk_eq("rst/trace_count", trace_count, 0);
        chk_eq("rst/trace_rd", rd_data, 0);
        reset = 1'b0;

        for (int k = 0; k < 256; k++) pat[k] = 5'(k & 1);
        do_run("toggle");

        fill_random(0);
        pat[10] = 5'd31; pat[11] = 5'd31;
        do_run("halt10");

        fill_random(0);
        pat[5] = 5'd31;
        do_run("glitch");

        for (int k = 0; k < 256; k++) pat[k] = 5'(k % 31);
        for (int k = 1; k <= 20; k++) pat[k] = 5'(k % 32);
        pat[21] = 5'd31; pat[22] = 5'd31;
        do_run("wrap");

        fill_random(0);
        pat[2] = 5'd31; pat[3] = 5'd31;
        do_run("short");

        // Reset in the middle of a run started from HALTED
        fill_random(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1 state_in = pat[c];
        end
        @(negedge clk);
        chk_eq("midrst/pre_count", cycle_count, 6);
        chk_eq("midrst/pre_running", running, 1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_eq("midrst/core_reset", core_reset, 1);
        chk_eq("midrst/running", running, 0);
        chk_eq("midrst/done", done, 0);
        chk_eq("midrst/timeout", timeout, 0);
        chk_eq("midrst/cycle_count", cycle_count, 0);
        chk_eq("midrst/trace_count", trace_count, 0);
        chk_eq("midrst/trace_rd", rd_data, 0);

        fill_random(0);
        pat[7] = 5'd31; pat[8] = 5'd31;
        do_run("restart1");
        fill_random(10);
        do_run("restart2");

        for (int r = 0; r < 8; r++) begin
            fill_random($urandom_range(45));
            do_run($sformatf("rnd%0d", r));
        end

        for (int k = 0; k < 256; k++) pat[k] = 5'd0;
        pat[4] = 5'd31;
        do_run4("p4_tie");
        for (int k = 0; k < 256; k++) pat[k] = 5'(k % 31);
        do_run4("p4_tmo");
        for (int k = 0; k < 256; k++) pat[k] = 5'd3;
        pat[2] = 5'd31;
        do_run4("p4_halt2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
